// File: rtl/vx_mem_arb2_if.sv
// vx_mem_arb2_if: requester-side and memory-side buses of the two-requester memory arbiter
interface vx_mem_arb2_if #(
    parameter int DATA_W   = 512,
    parameter int ADDR_W   = 26,
    parameter int BYTEEN_W = 64,
    parameter int TAG_W    = 8
);
    logic [1:0]            in_req_valid;
    logic [1:0]            in_req_rw;
    logic [2*BYTEEN_W-1:0] in_req_byteen;
    logic [2*ADDR_W-1:0]   in_req_addr;
    logic [2*DATA_W-1:0]   in_req_data;
    logic [2*TAG_W-1:0]    in_req_tag;
    logic [1:0]            in_req_ready;
    logic [1:0]            in_rsp_valid;
    logic [DATA_W-1:0]     in_rsp_data;
    logic [TAG_W-1:0]      in_rsp_tag;
    logic [1:0]            in_rsp_ready;
    logic                  mem_req_valid;
    logic                  mem_req_rw;
    logic [BYTEEN_W-1:0]   mem_req_byteen;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic [DATA_W-1:0]     mem_req_data;
    logic [TAG_W:0]        mem_req_tag;
    logic                  mem_req_ready;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_data;
    logic [TAG_W:0]        mem_rsp_tag;
    logic                  mem_rsp_ready;
    // arbiter view
    modport slave (
        input  in_req_valid, in_req_rw, in_req_byteen, in_req_addr, in_req_data, in_req_tag,
        output in_req_ready,
        output in_rsp_valid, in_rsp_data, in_rsp_tag,
        input  in_rsp_ready,
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );
    // requesters and memory view
    modport master (
        output in_req_valid, in_req_rw, in_req_byteen, in_req_addr, in_req_data, in_req_tag,
        input  in_req_ready,
        input  in_rsp_valid, in_rsp_data, in_rsp_tag,
        output in_rsp_ready,
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/vx_mem_arb2.sv
// vx_mem_arb2: round-robin two-requester arbiter onto one registered memory port with response routing
module vx_mem_arb2 #(
    parameter int DATA_W   = 512,
    parameter int ADDR_W   = 26,
    parameter int BYTEEN_W = 64,
    parameter int TAG_W    = 8,
    parameter int MAX_OUTS = 8
) (
    input  logic clk,
    input  logic reset,
    vx_mem_arb2_if.slave bus,
    output logic busy
);
    localparam int CNT_W = $clog2(MAX_OUTS + 1);

    logic [1:0][CNT_W-1:0] outs;
    logic                  rr;
    logic [1:0]            elig, grant, inc, dec;
    logic                  load, sel, src, rsp_hs;
    logic [BYTEEN_W-1:0]   sel_byteen;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic [TAG_W-1:0]      sel_tag;

    // arbitration: reads are eligible only below the outstanding cap; grant only when the output stage can load
    always_comb begin
        for (int i = 0; i < 2; i++)
            elig[i] = bus.in_req_valid[i] & (bus.in_req_rw[i] | (outs[i] < CNT_W'(MAX_OUTS)));
        load = ~bus.mem_req_valid | bus.mem_req_ready;
        grant = (~load | reset) ? 2'b00 : (&elig) ? (rr ? 2'b10 : 2'b01) : elig;
        bus.in_req_ready = grant;
        sel = grant[1];
        sel_byteen = sel ? bus.in_req_byteen[2*BYTEEN_W-1:BYTEEN_W] : bus.in_req_byteen[BYTEEN_W-1:0];
        sel_addr = sel ? bus.in_req_addr[2*ADDR_W-1:ADDR_W] : bus.in_req_addr[ADDR_W-1:0];
        sel_data = sel ? bus.in_req_data[2*DATA_W-1:DATA_W] : bus.in_req_data[DATA_W-1:0];
        sel_tag = sel ? bus.in_req_tag[2*TAG_W-1:TAG_W] : bus.in_req_tag[TAG_W-1:0];
    end

    // response routing by source bit and outstanding-count bookkeeping
    always_comb begin
        src = bus.mem_rsp_tag[TAG_W];
        bus.mem_rsp_ready = bus.in_rsp_ready[src];
        bus.in_rsp_valid = bus.mem_rsp_valid ? (src ? 2'b10 : 2'b01) : 2'b00;
        bus.in_rsp_data = bus.mem_rsp_data;
        bus.in_rsp_tag = bus.mem_rsp_tag[TAG_W-1:0];
        rsp_hs = bus.mem_rsp_valid & bus.mem_rsp_ready;
        for (int i = 0; i < 2; i++) begin
            inc[i] = grant[i] & ~bus.in_req_rw[i];
            dec[i] = rsp_hs & (src == i[0]) & (outs[i] != '0);
        end
        busy = bus.mem_req_valid | (|outs);
    end

    // output request register: load on grant, drop valid once memory takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_rw <= 1'b0;
            bus.mem_req_byteen <= '0;
            bus.mem_req_addr <= '0;
            bus.mem_req_data <= '0;
            bus.mem_req_tag <= '0;
            rr <= 1'b0;
        end else if (|grant) begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_rw <= bus.in_req_rw[sel];
            bus.mem_req_byteen <= sel_byteen;
            bus.mem_req_addr <= sel_addr;
            bus.mem_req_data <= sel_data;
            bus.mem_req_tag <= {sel, sel_tag};
            rr <= ~sel;
        end else if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
        end
    end

    // per-requester outstanding read counters; simultaneous issue and retire cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            outs <= '0;
        else
            for (int i = 0; i < 2; i++)
                outs[i] <= outs[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
    end

    rsp_without_outstanding: assert property (@(posedge clk) disable iff (reset) !(rsp_hs && outs[src] == '0));
endmodule

// File: tb/tb_vx_mem_arb2.sv
// tb_vx_mem_arb2: directed self-checking bench for the two-requester memory arbiter
module tb_vx_mem_arb2;
    localparam int DATA_W = 512, ADDR_W = 26, BYTEEN_W = 64, TAG_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int checks = 0;
    int errors = 0;

    vx_mem_arb2_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTEEN_W(BYTEEN_W), .TAG_W(TAG_W)) bus ();

    vx_mem_arb2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTEEN_W(BYTEEN_W), .TAG_W(TAG_W), .MAX_OUTS(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    initial begin
        bus.in_req_valid = 2'b11;
        bus.in_req_rw = 2'b00;
        bus.in_req_byteen = '1;
        bus.in_req_addr = '0;
        bus.in_req_data = '0;
        bus.in_req_tag = '0;
        bus.in_rsp_ready = 2'b11;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = '0;
        bus.mem_rsp_tag = '0;
        tick();
        tick();
        chk("rst_ready", 64'(bus.in_req_ready), 64'h0);
        chk("rst_valid", 64'(bus.mem_req_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_tag", 64'(bus.mem_req_tag), 64'h0);
        reset = 1'b0;
        bus.in_req_valid = 2'b00;

        // single read from requester 0
        bus.in_req_valid = 2'b01;
        bus.in_req_addr[ADDR_W-1:0] = 26'h400A;
        bus.in_req_tag[TAG_W-1:0] = 8'h05;
        #1;
        chk("t1_ready", 64'(bus.in_req_ready), 64'h1);
        tick();
        bus.in_req_valid = 2'b00;
        chk("t1_mvalid", 64'(bus.mem_req_valid), 64'h1);
        chk("t1_mtag", 64'(bus.mem_req_tag), 64'h005);
        chk("t1_maddr", 64'(bus.mem_req_addr), 64'h400A);
        chk("t1_mrw", 64'(bus.mem_req_rw), 64'h0);
        chk("t1_busy", 64'(busy), 64'h1);
        tick();
        chk("t1_mvalid_drop", 64'(bus.mem_req_valid), 64'h0);
        chk("t1_busy_outs", 64'(busy), 64'h1);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag = 9'h005;
        bus.mem_rsp_data[63:0] = 64'hDEAD_BEEF_0123_4567;
        #1;
        chk("t1_rsp_valid", 64'(bus.in_rsp_valid), 64'h1);
        chk("t1_rsp_tag", 64'(bus.in_rsp_tag), 64'h05);
        chk("t1_rsp_data", bus.in_rsp_data[63:0], 64'hDEAD_BEEF_0123_4567);
        chk("t1_mrsp_ready", 64'(bus.mem_rsp_ready), 64'h1);
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("t1_idle", 64'(busy), 64'h0);

        // both requesting writes: pointer favours requester 1 after the last grant to 0
        bus.in_req_valid = 2'b11;
        bus.in_req_rw = 2'b11;
        bus.in_req_tag = {8'h20, 8'h10};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_ready", 64'(bus.in_req_ready), (k % 2 == 0) ? 64'h2 : 64'h1);
            tick();
            chk("t2_mvalid", 64'(bus.mem_req_valid), 64'h1);
            chk("t2_mtag", 64'(bus.mem_req_tag), (k % 2 == 0) ? 64'h120 : 64'h010);
        end
        bus.in_req_valid = 2'b00;
        tick();
        chk("t2_drain", 64'(bus.mem_req_valid), 64'h0);

        // memory backpressure holds the output register
        bus.in_req_valid = 2'b01;
        bus.in_req_rw = 2'b01;
        bus.in_req_addr[ADDR_W-1:0] = 26'h1234;
        bus.in_req_tag[TAG_W-1:0] = 8'h33;
        bus.in_req_data[63:0] = 64'hCAFE_F00D_0000_0042;
        bus.mem_req_ready = 1'b0;
        #1;
        chk("t3_ready", 64'(bus.in_req_ready), 64'h1);
        tick();
        bus.in_req_valid = 2'b11;
        bus.in_req_addr[ADDR_W-1:0] = 26'h5555;
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_ready", 64'(bus.in_req_ready), 64'h0);
            chk("t3_hold_valid", 64'(bus.mem_req_valid), 64'h1);
            chk("t3_hold_addr", 64'(bus.mem_req_addr), 64'h1234);
            chk("t3_hold_tag", 64'(bus.mem_req_tag), 64'h033);
            tick();
        end
        chk("t3_hold_data", bus.mem_req_data[63:0], 64'hCAFE_F00D_0000_0042);
        chk("t3_hold_rw", 64'(bus.mem_req_rw), 64'h1);
        bus.in_req_valid = 2'b00;
        bus.mem_req_ready = 1'b1;
        tick();
        chk("t3_drain", 64'(bus.mem_req_valid), 64'h0);

        // outstanding cap on requester 1
        bus.in_req_valid = 2'b10;
        bus.in_req_rw = 2'b00;
        bus.in_req_tag[2*TAG_W-1:TAG_W] = 8'h40;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t4_ready", 64'(bus.in_req_ready), 64'h2);
            tick();
        end
        chk("t4_stall", 64'(bus.in_req_ready), 64'h0);
        chk("t4_mtag", 64'(bus.mem_req_tag), 64'h140);
        tick();
        chk("t4_stall_idle", 64'(bus.in_req_ready), 64'h0);
        chk("t4_mvalid_drop", 64'(bus.mem_req_valid), 64'h0);
        bus.in_req_rw = 2'b10;
        #1;
        chk("t4_write_ok", 64'(bus.in_req_ready), 64'h2);
        bus.in_req_rw = 2'b00;
        #1;
        chk("t4_read_stall", 64'(bus.in_req_ready), 64'h0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag = 9'h140;
        #1;
        chk("t4_rsp_valid", 64'(bus.in_rsp_valid), 64'h2);
        chk("t4_mrsp_ready", 64'(bus.mem_rsp_ready), 64'h1);
        chk("t4_still_stall", 64'(bus.in_req_ready), 64'h0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("t4_unstall", 64'(bus.in_req_ready), 64'h2);
        tick();
        bus.in_req_valid = 2'b00;
        chk("t4_9th_valid", 64'(bus.mem_req_valid), 64'h1);
        chk("t4_9th_tag", 64'(bus.mem_req_tag), 64'h140);
        chk("t4_busy", 64'(busy), 64'h1);

        // response backpressure passes through
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag = 9'h1A3;
        bus.in_rsp_ready = 2'b01;
        #1;
        chk("t5_mrsp_ready", 64'(bus.mem_rsp_ready), 64'h0);
        chk("t5_rsp_tag", 64'(bus.in_rsp_tag), 64'hA3);
        chk("t5_rsp_valid", 64'(bus.in_rsp_valid), 64'h2);
        tick();
        chk("t5_held_ready", 64'(bus.mem_rsp_ready), 64'h0);
        chk("t5_held_tag", 64'(bus.in_rsp_tag), 64'hA3);
        bus.in_rsp_ready = 2'b10;
        #1;
        chk("t5_release", 64'(bus.mem_rsp_ready), 64'h1);
        bus.mem_rsp_valid = 1'b0;
        bus.in_rsp_ready = 2'b11;

        // reset mid-operation with a pending request and reads outstanding
        bus.in_req_valid = 2'b01;
        bus.in_req_tag[TAG_W-1:0] = 8'h07;
        tick();
        tick();
        tick();
        bus.in_req_valid = 2'b00;
        bus.mem_req_ready = 1'b0;
        #1;
        chk("t6_pre_valid", 64'(bus.mem_req_valid), 64'h1);
        chk("t6_pre_busy", 64'(busy), 64'h1);
        bus.in_req_valid = 2'b11;
        reset = 1'b1;
        #1;
        chk("t6_valid", 64'(bus.mem_req_valid), 64'h0);
        chk("t6_busy", 64'(busy), 64'h0);
        chk("t6_ready", 64'(bus.in_req_ready), 64'h0);
        chk("t6_tag", 64'(bus.mem_req_tag), 64'h0);
        tick();
        chk("t6_busy_hold", 64'(busy), 64'h0);
        reset = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("t6_rr_reset", 64'(bus.in_req_ready), 64'h1);
        tick();
        bus.in_req_valid = 2'b00;
        chk("t6_reissue_tag", 64'(bus.mem_req_tag), 64'h007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
